// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU front-end: ALU op codes, MIPS
// R-type funct values, the FSM state type and the decoder output bundle.
package alu_pkg;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_NOR = 3'b100;
   localparam logic [2:0] ALU_XOR = 3'b101;
   localparam logic [2:0] ALU_SUB = 3'b110;

   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] FN_SUBU = 6'h23;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_XOR  = 6'h26;
   localparam logic [5:0] FN_NOR  = 6'h27;
   localparam logic [5:0] FN_SLT  = 6'h2A;
   localparam logic [5:0] FN_SLTU = 6'h2B;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   typedef struct packed {
      logic [2:0] op;
      logic       unsig;
      logic       slt;
      logic       illegal;
   } dec_t;

endpackage

// File: rtl/alu_funct_dec.sv
// Purely combinational decode of a MIPS R-type funct field into the ALU
// op code, unsigned flag, set-less-than flag and illegal flag.
module alu_funct_dec
   import alu_pkg::*;
(
   input  logic [5:0] funct,
   output dec_t       dec
);

   always_comb begin
      // NOTE: every output gets a default before the case so no latch is inferred.
      dec = '{op: ALU_AND, unsig: 1'b0, slt: 1'b0, illegal: 1'b0};
      unique case (funct)
         FN_ADD:  dec.op = ALU_ADD;
         FN_ADDU: begin dec.op = ALU_ADD; dec.unsig = 1'b1; end
         FN_SUB:  dec.op = ALU_SUB;
         FN_SUBU: begin dec.op = ALU_SUB; dec.unsig = 1'b1; end
         FN_AND:  dec.op = ALU_AND;
         FN_OR:   dec.op = ALU_OR;
         FN_XOR:  dec.op = ALU_XOR;
         FN_NOR:  dec.op = ALU_NOR;
         FN_SLT:  begin dec.op = ALU_SUB; dec.slt = 1'b1; end
         FN_SLTU: begin dec.op = ALU_SUB; dec.slt = 1'b1; dec.unsig = 1'b1; end
         default: dec.illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_seq.sv
// Sequential front-end for an external combinational ALU: one request in
// flight, IDLE -> EXEC -> DONE. Optional overflow trap: ALU_SEQ_OVF_TRAP_EN.
module alu_seq
   import alu_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [5:0]        funct,
   input  logic [DATA_W-1:0] rs_val,
   input  logic [DATA_W-1:0] rt_val,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [2:0]        alu_op,
   output logic              alu_unsig,
   input  logic [DATA_W-1:0] alu_out,
   input  logic              alu_compout,
   input  logic              alu_overflow,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] result,
   output logic              ovf,
   output logic              illegal,
   output logic              trap
);

   state_t            r_state;
   state_t            w_next;
   dec_t              w_dec;
   logic              w_hs;
   logic [DATA_W-1:0] r_a;
   logic [DATA_W-1:0] r_b;
   logic [2:0]        r_op;
   logic              r_unsig;
   logic              r_slt;
   logic [DATA_W-1:0] r_result;
   logic              r_ovf;
   logic              r_illegal;
   logic              w_ovf_en;
   logic              w_cap_ovf;
   logic [DATA_W-1:0] w_cap_result;

   alu_funct_dec u_dec (
      .funct (funct),
      .dec   (w_dec)
   );

   assign w_hs      = in_valid && in_ready;
   assign in_ready  = (r_state == ST_IDLE);
   assign out_valid = (r_state == ST_DONE);

   // NOTE: state elements use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         ST_IDLE: if (w_hs) w_next = w_dec.illegal ? ST_DONE : ST_EXEC;
         ST_EXEC: w_next = ST_DONE;
         ST_DONE: if (out_ready) w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   // Overflow is only meaningful for the signed ADD/SUB instructions, not for SLT.
   assign w_ovf_en  = !r_unsig && !r_slt && ((r_op == ALU_ADD) || (r_op == ALU_SUB));
   assign w_cap_ovf = w_ovf_en && alu_overflow;

`ifdef ALU_SEQ_OVF_TRAP_EN
   logic r_trap;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                r_trap <= 1'b0;
      else if ((r_state == ST_EXEC) && w_cap_ovf) r_trap <= 1'b1;
   end

   assign trap = r_trap;
   assign w_cap_result = w_cap_ovf ? '0
                       : (r_slt ? {{(DATA_W-1){1'b0}}, alu_compout} : alu_out);
`else
   assign trap = 1'b0;
   assign w_cap_result = r_slt ? {{(DATA_W-1){1'b0}}, alu_compout} : alu_out;
`endif

   // NOTE: these are plain flops, not a memory array, so they all take the async reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a       <= '0;
         r_b       <= '0;
         r_op      <= ALU_AND;
         r_unsig   <= 1'b0;
         r_slt     <= 1'b0;
         r_result  <= '0;
         r_ovf     <= 1'b0;
         r_illegal <= 1'b0;
      end else if ((r_state == ST_IDLE) && w_hs) begin
         if (w_dec.illegal) begin
            r_result  <= '0;
            r_ovf     <= 1'b0;
            r_illegal <= 1'b1;
         end else begin
            r_a       <= rs_val;
            r_b       <= rt_val;
            r_op      <= w_dec.op;
            r_unsig   <= w_dec.unsig;
            r_slt     <= w_dec.slt;
            r_illegal <= 1'b0;
         end
      end else if (r_state == ST_EXEC) begin
         r_result <= w_cap_result;
         r_ovf    <= w_cap_ovf;
      end
   end

   assign alu_a     = (r_state == ST_EXEC) ? r_a     : '0;
   assign alu_b     = (r_state == ST_EXEC) ? r_b     : '0;
   assign alu_op    = (r_state == ST_EXEC) ? r_op    : ALU_AND;
   assign alu_unsig = (r_state == ST_EXEC) ? r_unsig : 1'b0;

   assign result  = r_result;
   assign ovf     = r_ovf;
   assign illegal = r_illegal;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq with a behavioural ALU attached to its ALU ports.
module tb_alu_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [5:0]  funct;
   logic [31:0] rs_val, rt_val;
   logic [31:0] alu_a, alu_b, alu_out;
   logic [2:0]  alu_op;
   logic        alu_unsig, alu_compout, alu_overflow;
   logic        out_valid, out_ready;
   logic [31:0] result;
   logic        ovf, illegal, trap;

   typedef struct packed {
      logic [31:0] result;
      logic        ovf;
      logic        illegal;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_errors = 0;
   logic exp_trap = 1'b0;

   always #5 clk = ~clk;

   alu_seq #(.DATA_W(32)) dut (
      .clk (clk), .rst_n (rst_n),
      .in_valid (in_valid), .in_ready (in_ready), .funct (funct),
      .rs_val (rs_val), .rt_val (rt_val),
      .alu_a (alu_a), .alu_b (alu_b), .alu_op (alu_op), .alu_unsig (alu_unsig),
      .alu_out (alu_out), .alu_compout (alu_compout), .alu_overflow (alu_overflow),
      .out_valid (out_valid), .out_ready (out_ready),
      .result (result), .ovf (ovf), .illegal (illegal), .trap (trap)
   );

   // Behavioural ALU: overflow follows the op alone, the DUT must gate it.
   always_comb begin
      logic [31:0] s;
      logic [31:0] d;
      s = alu_a + alu_b;
      d = alu_a - alu_b;
      alu_out      = 32'h0;
      alu_overflow = 1'b0;
      alu_compout  = alu_unsig ? (alu_a < alu_b) : ($signed(alu_a) < $signed(alu_b));
      case (alu_op)
         3'b000: alu_out = alu_a & alu_b;
         3'b001: alu_out = alu_a | alu_b;
         3'b010: begin alu_out = s; alu_overflow = (alu_a[31] == alu_b[31]) && (s[31] != alu_a[31]); end
         3'b100: alu_out = ~(alu_a | alu_b);
         3'b101: alu_out = alu_a ^ alu_b;
         3'b110: begin alu_out = d; alu_overflow = (alu_a[31] != alu_b[31]) && (d[31] != alu_a[31]); end
         default: alu_out = 32'h0;
      endcase
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic exp_t ref_calc(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      logic [31:0] s, d;
      s = a + b;
      d = a - b;
      e = '{result: 32'h0, ovf: 1'b0, illegal: 1'b0};
      case (fn)
         6'h20: begin e.result = s; e.ovf = (a[31] == b[31]) && (s[31] != a[31]); end
         6'h21: e.result = s;
         6'h22: begin e.result = d; e.ovf = (a[31] != b[31]) && (d[31] != a[31]); end
         6'h23: e.result = d;
         6'h24: e.result = a & b;
         6'h25: e.result = a | b;
         6'h26: e.result = a ^ b;
         6'h27: e.result = ~(a | b);
         6'h2A: e.result = {31'b0, $signed(a) < $signed(b)};
         6'h2B: e.result = {31'b0, a < b};
         default: e.illegal = 1'b1;
      endcase
`ifdef ALU_SEQ_OVF_TRAP_EN
      if (e.ovf) e.result = 32'h0;
`endif
      return e;
   endfunction

   task automatic do_req(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b, input int hold);
      exp_t e;
      int   lat;
      int   exp_lat;
      e = ref_calc(fn, a, b);
      sb_q.push_back(e);
      exp_lat = e.illegal ? 1 : 2;
      @(negedge clk);
      check("in_ready_idle", {31'b0, in_ready}, 32'd1);
      in_valid = 1'b1; funct = fn; rs_val = a; rt_val = b;
      @(posedge clk);
      #1 in_valid = 1'b0; funct = 6'h00; rs_val = 32'h0; rt_val = 32'h0;
      lat = 0;
      while (lat < 8) begin
         @(negedge clk);
         lat++;
         if (out_valid) break;
         check("exec_alu_a", alu_a, a);
         check("exec_alu_b", alu_b, b);
      end
      check("latency", lat, exp_lat);
      if (!out_valid) begin
         void'(sb_q.pop_back());
         return;
      end
      for (int i = 0; i < hold; i++) begin
         check("hold_valid", {31'b0, out_valid}, 32'd1);
         check("hold_in_ready", {31'b0, in_ready}, 32'd0);
         check("hold_result", result, e.result);
         @(negedge clk);
      end
      check("done_alu_op", {29'b0, alu_op}, 32'd0);
      check("done_alu_a", alu_a, 32'h0);
      check("done_alu_b", alu_b, 32'h0);
      check("done_alu_unsig", {31'b0, alu_unsig}, 32'd0);
      out_ready = 1'b1;
      e = sb_q.pop_front();
      check("result", result, e.result);
      check("ovf", {31'b0, ovf}, {31'b0, e.ovf});
      check("illegal", {31'b0, illegal}, {31'b0, e.illegal});
`ifdef ALU_SEQ_OVF_TRAP_EN
      if (e.ovf) exp_trap = 1'b1;
`endif
      check("trap", {31'b0, trap}, {31'b0, exp_trap});
      @(posedge clk);
      #1 out_ready = 1'b0;
      check("back_idle_valid", {31'b0, out_valid}, 32'd0);
      check("back_idle_ready", {31'b0, in_ready}, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [5:0] legal_fn [10];
      legal_fn = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
      rst_n = 1'b0; in_valid = 1'b0; funct = 6'h0; rs_val = 32'h0; rt_val = 32'h0; out_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_out_valid", {31'b0, out_valid}, 32'd0);
      check("rst_in_ready", {31'b0, in_ready}, 32'd1);
      check("rst_result", result, 32'h0);
      check("rst_trap", {31'b0, trap}, 32'd0);
      check("rst_alu_op", {29'b0, alu_op}, 32'd0);
      rst_n = 1'b1;

      do_req(6'h20, 32'd5, 32'd7, 0);
      do_req(6'h20, 32'h7FFF_FFFF, 32'd1, 0);
      do_req(6'h21, 32'h7FFF_FFFF, 32'd1, 0);
      do_req(6'h22, 32'h8000_0000, 32'd1, 0);
      do_req(6'h23, 32'd3, 32'd10, 0);
      do_req(6'h24, 32'hF0F0_1234, 32'h0FF0_FFFF, 0);
      do_req(6'h25, 32'hF0F0_0000, 32'h0000_1234, 0);
      do_req(6'h26, 32'hAAAA_5555, 32'hFFFF_0000, 0);
      do_req(6'h27, 32'h1234_0000, 32'h0000_5678, 0);
      do_req(6'h2A, 32'hFFFF_FFFF, 32'd1, 0);
      do_req(6'h2B, 32'hFFFF_FFFF, 32'd1, 0);
      do_req(6'h3F, 32'h1111_1111, 32'h2222_2222, 0);
      do_req(6'h22, 32'd100, 32'd58, 5);
      do_req(6'h3F, 32'h0, 32'h0, 3);
      for (int i = 0; i < 12; i++)
         do_req(legal_fn[$urandom_range(0, 9)], $urandom, $urandom, $urandom_range(0, 2));

      // Reset pulsed while a request sits in EXEC.
      @(negedge clk);
      in_valid = 1'b1; funct = 6'h20; rs_val = 32'd9; rt_val = 32'd9;
      sb_q.push_back(ref_calc(6'h20, 32'd9, 32'd9));
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      check("exec_before_rst", {29'b0, alu_op}, 32'd2);
      rst_n = 1'b0;
      #1;
      check("rst_exec_valid", {31'b0, out_valid}, 32'd0);
      check("rst_exec_ready", {31'b0, in_ready}, 32'd1);
      check("rst_exec_result", result, 32'h0);
      check("rst_exec_alu_op", {29'b0, alu_op}, 32'd0);
      check("rst_exec_trap", {31'b0, trap}, 32'd0);
      void'(sb_q.pop_back());
      exp_trap = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("no_resp_after_rst", {31'b0, out_valid}, 32'd0);
      end
      do_req(6'h20, 32'd5, 32'd7, 1);
      check("sb_empty", sb_q.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/result width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  request present.
REQ-005 SHALL have port in_ready  output  1  request accepted when in_valid and in_ready are both high.
REQ-006 SHALL have port funct  input  6  MIPS R-type funct field.
REQ-007 SHALL have ports rs_val, rt_val  input  DATA_W  source operands.
REQ-008 SHALL have ports alu_a, alu_b  output  DATA_W; alu_op  output  3; alu_unsig  output  1  ALU drive.
REQ-009 SHALL have ports alu_out  input  DATA_W; alu_compout, alu_overflow  input  1  ALU response (combinational).
REQ-010 SHALL have port out_valid  output  1  response present.
REQ-011 SHALL have port out_ready  input  1  response consumed when out_valid and out_ready are both high.
REQ-012 SHALL have ports result  output  DATA_W; ovf, illegal, trap  output  1  response fields.

Function
REQ-013 SHALL decode funct as follows: 0x20 ADD, 0x21 ADD unsig, 0x22 SUB, 0x23 SUB unsig, 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR, 0x2A SLT (SUB, signed), 0x2B SLTU (SUB unsig); any other value is illegal.
REQ-014 SHALL use ALU op codes AND 000, OR 001, ADD 010, NOR 100, XOR 101, SUB 110.
REQ-015 SHALL implement FSM states IDLE, EXEC, DONE; reset state is IDLE.
REQ-016 SHALL drive in_ready high only in IDLE.
REQ-017 IDLE: on handshake with a legal funct, SHALL register operands, op, unsig and the SLT flag, then go to EXEC.
REQ-018 IDLE: on handshake with an illegal funct, SHALL go directly to DONE with result=0, illegal=1, ovf=0.
REQ-019 EXEC: SHALL hold the registered values on alu_a/alu_b/alu_op/alu_unsig for exactly one cycle, capture the ALU response, then go to DONE.
REQ-020 SHALL capture result as alu_out, or as {31'b0, alu_compout} for SLT/SLTU.
REQ-021 SHALL capture ovf as alu_overflow for signed ADD/SUB only, and as 0 otherwise.
REQ-022 DONE: SHALL hold out_valid high with result/ovf/illegal stable until out_ready is high, then go to IDLE.
REQ-023 Legal-request latency SHALL be 2 cycles from handshake to out_valid; illegal-request latency SHALL be 1 cycle; at most one request is in flight.
REQ-024 SHALL drive alu_op=000, alu_a=0, alu_b=0 and alu_unsig=0 outside EXEC.

Reset
REQ-025 On rst_n low, SHALL immediately force state=IDLE, out_valid=0, result=0, ovf=0, illegal=0, trap=0 and all operand registers to 0.
REQ-026 Reset asserted in EXEC or DONE SHALL discard the in-flight request with no response.

Configuration
REQ-027 With ALU_SEQ_OVF_TRAP_EN defined, a captured ovf=1 SHALL set trap sticky-high until reset and SHALL replace that response's result with 0.
REQ-028 Without ALU_SEQ_OVF_TRAP_EN, trap SHALL be tied 0 and result SHALL be unaffected by ovf.

Structure
REQ-029 Package alu_pkg SHALL hold the ALU op-code constants, the funct constants and the FSM state enumerated type.
REQ-030 Sub-module alu_funct_dec SHALL perform the purely combinational decode funct -> {op, unsig, slt, illegal}.

Verification
REQ-031 Scenario: ADD rs=5, rt=7, out_ready=1 -> out_valid 2 cycles after handshake, result=12, ovf=0.
REQ-032 Scenario: ADD 0x7FFFFFFF+1 -> ovf=1; with ALU_SEQ_OVF_TRAP_EN result=0 and trap stays 1; without it result=0x80000000 and trap=0; ADDU of the same operands -> ovf=0.
REQ-033 Scenario: SLT rs=-1, rt=1 -> result=1; SLTU with the same operands -> result=0.
REQ-034 Scenario: funct=0x3F -> out_valid 1 cycle after handshake, illegal=1, result=0, ALU ports stay idle.
REQ-035 Scenario: out_ready held low for 5 cycles -> out_valid and result stable throughout, in_ready=0; out_ready high -> IDLE next cycle.
REQ-036 Scenario: rst_n pulsed low during EXEC -> immediate IDLE, out_valid=0, no response emitted, next request handled normally.
